// File: rtl/vtile_config_ctx_pkg.sv
// Shared types and default sizing for the multi-context vector tile configuration memory.
package vtile_cfg_pkg;

  localparam int VT_WIDTH      = 16;
  localparam int VT_NUM_INPUTS = 8;
  localparam int VT_NUM_CTX    = 4;
  localparam int VT_REP_W      = 4;
  localparam int VT_CTX_W      = $clog2(VT_NUM_CTX);

  typedef logic [VT_CTX_W-1:0] ctx_idx_t;
  typedef logic [VT_WIDTH-1:0] word_t;
  typedef word_t vec_t [VT_NUM_INPUTS+1];

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/vtile_config_ctx_bank.sv
// Context storage: NUM_CTX vectors of NUM_INPUTS+1 words, one write port and one
// registered read port that either loads a context, clears to zero, or holds.
module config_ctx_bank #(
  parameter int WIDTH      = 16,
  parameter int NUM_INPUTS = 8,
  parameter int NUM_CTX    = 4,
  parameter int CTX_W      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [CTX_W-1:0] wr_ctx,
  input  logic [WIDTH-1:0] wr_data [NUM_INPUTS+1],
  input  logic             rd_load,
  input  logic             rd_clear,
  input  logic [CTX_W-1:0] rd_ctx,
  output logic [WIDTH-1:0] rd_data [NUM_INPUTS+1]
);

  logic [WIDTH-1:0] mem [NUM_CTX][NUM_INPUTS+1];

  // Storage is deliberately not reset; validity is tracked outside.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i <= NUM_INPUTS; i++) begin
        mem[wr_ctx][i] <= wr_data[i];
      end
    end
  end

  // The read register samples pre-write contents when load and write coincide.
  always_ff @(posedge clk) begin
    if (reset || rd_clear) begin
      for (int i = 0; i <= NUM_INPUTS; i++) begin
        rd_data[i] <= '0;
      end
    end else if (rd_load) begin
      for (int i = 0; i <= NUM_INPUTS; i++) begin
        rd_data[i] <= mem[rd_ctx][i];
      end
    end
  end

endmodule

// File: rtl/vtile_config_ctx.sv
// Multi-context configuration memory: network writes fill contexts while a run
// request issues one stored vector to the vector FU for 1..2^REP_W cycles.
module vtile_config_ctx
  import vtile_cfg_pkg::*;
#(
  parameter int  WIDTH      = VT_WIDTH,
  parameter int  NUM_INPUTS = VT_NUM_INPUTS,
  parameter int  NUM_CTX    = VT_NUM_CTX,
  parameter int  REP_W      = VT_REP_W,
  localparam int CTX_W      = $clog2(NUM_CTX)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               write_en,
  output logic               write_rdy,
  input  logic [CTX_W-1:0]   w_ctx,
  input  logic [WIDTH-1:0]   w_data_in [NUM_INPUTS+1],
  output logic               write_ack,
  input  logic [NUM_CTX-1:0] clear_ctx,
  input  logic               on_off,
  input  logic [CTX_W-1:0]   run_ctx,
  input  logic [REP_W-1:0]   run_reps,
  output logic [WIDTH-1:0]   r_data_out [NUM_INPUTS+1],
  output logic               on_off_vector_fu,
  output logic               busy,
  output logic               run_err,
  output logic [NUM_CTX-1:0] ctx_valid
);

  state_t             state, state_nxt;
  logic [CTX_W-1:0]   cur_ctx;
  logic [REP_W-1:0]   rep_cnt;
  logic               run_start, run_last, run_reject;
  logic               write_acc;
  logic [NUM_CTX-1:0] valid_nxt;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    run_start  = 1'b0;
    run_last   = 1'b0;
    run_reject = 1'b0;
    case (state)
      IDLE: begin
        if (on_off) begin
          if (ctx_valid[run_ctx]) begin
            run_start = 1'b1;
            state_nxt = RUN;
          end else begin
            run_reject = 1'b1;
          end
        end
      end
      RUN: begin
        if (rep_cnt == '0) begin
          run_last  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy             = (state == RUN);
  assign on_off_vector_fu = busy;
  assign write_rdy        = !(busy && (w_ctx == cur_ctx));
  assign write_acc        = write_en && write_rdy;

  // A write to a context beats a clear of the same context in the same cycle.
  always_comb begin
    valid_nxt = ctx_valid & ~clear_ctx;
    if (write_acc) valid_nxt[w_ctx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_ctx   <= '0;
      rep_cnt   <= '0;
      write_ack <= 1'b0;
      run_err   <= 1'b0;
      ctx_valid <= '0;
    end else begin
      write_ack <= write_acc;
      run_err   <= run_reject;
      ctx_valid <= valid_nxt;
      if (run_start) begin
        cur_ctx <= run_ctx;
        rep_cnt <= run_reps;
      end else if (busy && (rep_cnt != '0)) begin
        rep_cnt <= rep_cnt - 1'b1;
      end
    end
  end

  // The issued vector is loaded once at run start and held, so a same-cycle
  // write to the starting context cannot leak into later issues.
  config_ctx_bank #(
    .WIDTH      (WIDTH),
    .NUM_INPUTS (NUM_INPUTS),
    .NUM_CTX    (NUM_CTX),
    .CTX_W      (CTX_W)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (write_acc),
    .wr_ctx   (w_ctx),
    .wr_data  (w_data_in),
    .rd_load  (run_start),
    .rd_clear (run_last),
    .rd_ctx   (run_ctx),
    .rd_data  (r_data_out)
  );

endmodule

// File: doc/vtile_config_ctx.md
# vtile_config_ctx

Multi-context configuration memory for the vector tile, replacing the single-context config memory. The CGRA network writes complete operand/config vectors into any of `NUM_CTX` contexts while the vector FU executes from another. A run request selects a context and a repeat count, and the block issues that context's vector to the vector FU for that many consecutive cycles. Per-context valid tracking rejects runs of contexts that were never written or have been cleared.

## Interface
- `WIDTH`, 16, bits per word
- `NUM_INPUTS`, 8, highest word index; each vector has `NUM_INPUTS+1` words
- `NUM_CTX`, 4, number of contexts (power of two, ≥2)
- `REP_W`, 4, width of the repeat-count field
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `write_en` in 1: network write valid; held until accepted
- `write_rdy` out 1: write accepted this cycle when `write_en && write_rdy`
- `w_ctx` in `$clog2(NUM_CTX)`: target context of the write
- `w_data_in` in `[WIDTH-1:0] [NUM_INPUTS:0]`: write vector
- `write_ack` out 1: one-cycle pulse, the cycle after acceptance
- `clear_ctx` in `NUM_CTX`: one-hot/multi-hot; invalidates the selected contexts
- `on_off` in 1: run request, a one-cycle pulse
- `run_ctx` in `$clog2(NUM_CTX)`: context to run
- `run_reps` in `REP_W`: number of issues minus 1 (0 means one issue)
- `r_data_out` out `[WIDTH-1:0] [NUM_INPUTS:0]`: vector issued to the FU
- `on_off_vector_fu` out 1: high in every issue cycle; `r_data_out` is valid only while it is high
- `busy` out 1: high while in RUN
- `run_err` out 1: one-cycle pulse when a run request is rejected
- `ctx_valid` out `NUM_CTX`: per-context written-and-not-cleared flags

## Operation
- FSM has two states, IDLE and RUN.
  - IDLE → RUN on `on_off` when `ctx_valid[run_ctx]`. The block latches `run_ctx` into `cur_ctx` and `run_reps` into `rep_cnt`.
  - RUN → IDLE after the issue in which `rep_cnt == 0`. Otherwise each issue decrements `rep_cnt`.
- While in RUN, `on_off` is ignored (no error).
- Run rejection: `on_off` in IDLE with `!ctx_valid[run_ctx]` → `run_err` pulses next cycle, FSM stays in IDLE, no issue occurs.
- Write acceptance: `write_rdy = !(busy && w_ctx == cur_ctx)`. Writes to any non-running context are accepted in either state.
- Accepted write: at that edge the vector is stored to `w_ctx` and `ctx_valid[w_ctx]` is set.
- Clear vs write to the same context on the same cycle: the write wins and the context stays valid.
- Clear of the running context: takes effect on `ctx_valid` immediately. The run in progress completes using the stored data, which is retained.
- Write and `on_off` to the same context on the same cycle in IDLE: the run is evaluated against the pre-write `ctx_valid` and pre-write data. The write is still accepted.
- Reset mid-RUN: FSM returns to IDLE, all issues stop, all `ctx_valid` bits clear. Storage contents are don't-care.

## Timing
- Reset values: `write_rdy`=1, `write_ack`=0, `on_off_vector_fu`=0, `r_data_out`=0, `busy`=0, `run_err`=0, `ctx_valid`=0.
- Write latency: acceptance at edge N → `write_ack` high during cycle N+1. A following write may be accepted in cycle N+1 (one per cycle).
- Run latency: `on_off` sampled at edge N → first issue (`on_off_vector_fu`=1) in cycle N+1, then `run_reps` further consecutive issues. `busy` is high for the same cycles.
- `r_data_out` is registered from storage. It holds 0 whenever `on_off_vector_fu` is 0.
- A new `on_off` is accepted in the cycle after the last issue, giving back-to-back runs with no bubble beyond one cycle.

## Structure
- Package `vtile_cfg_pkg` holds:
  - `ctx_idx_t` typedef
  - `vec_t` typedef (unpacked word array)
  - the state enum `{IDLE, RUN}`
- Sub-module `config_ctx_bank`: `NUM_CTX`×(`NUM_INPUTS+1`) word storage with one write port and one registered read port.
- The top level holds the FSM, the repeat counter, the valid flags and the handshake logic.

## Test plan
- Reset, then `on_off` with `run_ctx`=0 → `run_err` pulse, no issue, `ctx_valid`=0000.
- Write ctx1 with words = index+0x10 → `write_ack` next cycle, `ctx_valid`=0010. Run ctx1 with reps=0 → exactly one issue, `r_data_out[3]`=0x13.
- Run ctx1 with reps=3 → four consecutive issues. `write_en` to ctx1 during the run sees `write_rdy`=0; `write_en` to ctx2 during the run is accepted with ack.
- Same cycle: write ctx0 and `clear_ctx`=0001 → `ctx_valid[0]`=1. `clear_ctx`=0010 during a ctx1 run → the run finishes all issues and `ctx_valid[1]`=0 afterwards.
- Same cycle: `on_off` ctx2 (previously valid, old data A) and write ctx2 with data B → issue shows A. The next run shows B.
- Assert `reset` in the 2nd issue of a 4-issue run → `on_off_vector_fu`=0 from the next cycle, `busy`=0, `ctx_valid`=0.
